// File: rtl/sitcp_xg_tx_arbiter.sv
// rtl/sitcp_xg_tx_arbiter.sv - round-robin arbiter sharing the SiTCP XG TCP transmit port
module sitcp_xg_tx_arbiter #(
   parameter int NUM_SRC      = 4,
   parameter int MAX_BURST    = 256,
   parameter int IDLE_TIMEOUT = 16
) (
   input  logic                   XGMII_CLOCK,
   input  logic                   RSTn,
   input  logic [NUM_SRC-1:0]     SRC_VALID,
   output logic [NUM_SRC-1:0]     SRC_READY,
   input  logic [NUM_SRC-1:0]     SRC_LAST,
   input  logic [64*NUM_SRC-1:0]  SRC_D,
   input  logic [4*NUM_SRC-1:0]   SRC_B,
   input  logic                   USER_SESSION_ESTABLISHED,
   input  logic                   USER_SESSION_CLOSE_REQ,
   output logic                   USER_SESSION_CLOSE_ACK,
   input  logic                   USER_TX_AFULL,
   output logic [63:0]            USER_TX_D,
   output logic [3:0]             USER_TX_B,
   output logic [2:0]             GNT_ID,
   output logic                   BUSY,
   output logic [31:0]            TX_WORD_CNT
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARB   = 2'd1;
   localparam logic [1:0] ST_XFER  = 2'd2;
   localparam logic [1:0] ST_CLOSE = 2'd3;

   logic [1:0]  state;
   logic [2:0]  gnt;
   logic [2:0]  ptr;
   logic [2:0]  pick;
   logic        any_valid;
   logic        valid_g;
   logic        last_g;
   logic [63:0] d_g;
   logic [3:0]  b_g;
   logic [3:0]  b_clamp;
   logic        ready_g;
   logic        accept;
   logic [15:0] burst_cnt;
   logic [7:0]  idle_cnt;
   logic        close_ack;
   logic [63:0] tx_d;
   logic [3:0]  tx_b;
   logic [31:0] word_cnt;

   always_comb begin
      valid_g = 1'b0;
      last_g  = 1'b0;
      d_g     = '0;
      b_g     = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (gnt == 3'(i)) begin
            valid_g = SRC_VALID[i];
            last_g  = SRC_LAST[i];
            d_g     = SRC_D[64*i +: 64];
            b_g     = SRC_B[4*i +: 4];
         end
      end
   end

   // Session loss and close request gate READY in the same cycle, not one edge later.
   assign ready_g = (state == ST_XFER) & USER_SESSION_ESTABLISHED
                  & ~USER_SESSION_CLOSE_REQ & ~USER_TX_AFULL;
   assign accept  = ready_g & valid_g;
   assign b_clamp = (b_g > 4'd8) ? 4'd8 : b_g;

   always_comb begin
      SRC_READY = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         SRC_READY[i] = ready_g & (gnt == 3'(i));
      end
   end

   // Scan from farthest to nearest so the source closest after ptr wins.
   always_comb begin
      pick      = '0;
      any_valid = 1'b0;
      for (int k = NUM_SRC; k >= 1; k--) begin
         if (SRC_VALID[(int'(ptr) + k) % NUM_SRC]) begin
            pick      = 3'((int'(ptr) + k) % NUM_SRC);
            any_valid = 1'b1;
         end
      end
   end

   always_ff @(posedge XGMII_CLOCK) begin
      if (!RSTn) begin
         state     <= ST_IDLE;
         gnt       <= '0;
         ptr       <= 3'(NUM_SRC - 1);
         burst_cnt <= '0;
         idle_cnt  <= '0;
         close_ack <= 1'b0;
         tx_d      <= '0;
         tx_b      <= '0;
         word_cnt  <= '0;
      end else begin
         close_ack <= USER_SESSION_CLOSE_REQ;
         tx_b      <= accept ? b_clamp : 4'd0;
         if (accept) begin
            tx_d <= d_g;
            if (b_g != 4'd0) begin
               word_cnt <= word_cnt + 32'd1;
            end
         end
         if (USER_SESSION_CLOSE_REQ) begin
            state <= ST_CLOSE;
         end else if (!USER_SESSION_ESTABLISHED) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: state <= ST_ARB;
               ST_ARB: begin
                  if (any_valid) begin
                     gnt       <= pick;
                     ptr       <= pick;
                     burst_cnt <= '0;
                     idle_cnt  <= '0;
                     state     <= ST_XFER;
                  end
               end
               ST_XFER: begin
                  if (accept) begin
                     burst_cnt <= burst_cnt + 16'd1;
                     idle_cnt  <= '0;
                     if (last_g || burst_cnt == 16'(MAX_BURST - 1)) begin
                        state <= ST_ARB;
                     end
                  end else if (!valid_g) begin
                     idle_cnt <= idle_cnt + 8'd1;
                     if (idle_cnt == 8'(IDLE_TIMEOUT - 1)) begin
                        state <= ST_ARB;
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign USER_SESSION_CLOSE_ACK = close_ack;
   assign USER_TX_D              = tx_d;
   assign USER_TX_B              = tx_b;
   assign GNT_ID                 = gnt;
   assign BUSY                   = (state == ST_XFER);
   assign TX_WORD_CNT            = word_cnt;

endmodule

// File: tb/tb_sitcp_xg_tx_arbiter.sv
// tb/tb_sitcp_xg_tx_arbiter.sv - randomized scoreboard bench for sitcp_xg_tx_arbiter
module tb_sitcp_xg_tx_arbiter;

   localparam int NUM_SRC      = 4;
   localparam int MAX_BURST    = 4;
   localparam int IDLE_TIMEOUT = 16;
   localparam int NCYC         = 6000;

   localparam int M_IDLE  = 0;
   localparam int M_ARB   = 1;
   localparam int M_XFER  = 2;
   localparam int M_CLOSE = 3;

   typedef struct {
      logic [NUM_SRC-1:0] ready;
      logic               busy;
      logic [2:0]         gnt;
      logic               ack;
      logic [63:0]        txd;
      logic [31:0]        cnt;
   } ctrl_t;

   typedef struct {
      int          cyc;
      logic [63:0] d;
      logic [3:0]  b;
   } word_t;

   logic                  clk = 1'b0;
   logic                  rstn;
   logic [NUM_SRC-1:0]    src_valid;
   logic [NUM_SRC-1:0]    src_ready;
   logic [NUM_SRC-1:0]    src_last;
   logic [64*NUM_SRC-1:0] src_d;
   logic [4*NUM_SRC-1:0]  src_b;
   logic                  est;
   logic                  creq;
   logic                  ack;
   logic                  afull;
   logic [63:0]           tx_d;
   logic [3:0]            tx_b;
   logic [2:0]            gnt_id;
   logic                  busy;
   logic [31:0]           tx_cnt;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   ctrl_t ctrl_q[$];
   word_t dq[$];
   ctrl_t mon_e;
   word_t mon_w;

   // Per-source pending word and activity state
   logic [63:0] cur_d[NUM_SRC];
   logic [3:0]  cur_b[NUM_SRC];
   logic        cur_last[NUM_SRC];
   int          seq[NUM_SRC];
   int          mute[NUM_SRC];

   // Reference model of the arbiter
   int          m_mode;
   int          m_gnt;
   int          m_ptr;
   int          m_words;
   int          m_idle;
   logic        m_ack;
   logic [63:0] m_txd;
   logic [31:0] m_cnt;

   sitcp_xg_tx_arbiter #(
      .NUM_SRC(NUM_SRC), .MAX_BURST(MAX_BURST), .IDLE_TIMEOUT(IDLE_TIMEOUT)
   ) dut (
      .XGMII_CLOCK(clk), .RSTn(rstn),
      .SRC_VALID(src_valid), .SRC_READY(src_ready), .SRC_LAST(src_last),
      .SRC_D(src_d), .SRC_B(src_b),
      .USER_SESSION_ESTABLISHED(est), .USER_SESSION_CLOSE_REQ(creq),
      .USER_SESSION_CLOSE_ACK(ack), .USER_TX_AFULL(afull),
      .USER_TX_D(tx_d), .USER_TX_B(tx_b), .GNT_ID(gnt_id),
      .BUSY(busy), .TX_WORD_CNT(tx_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic new_word(input int s);
      int r;
      seq[s]++;
      cur_d[s] = {8'(s), 24'(seq[s]), 32'($urandom)};
      r = $urandom_range(0, 15);
      if (r == 0) cur_b[s] = 4'd0;
      else if (r == 1) cur_b[s] = 4'($urandom_range(9, 15));
      else cur_b[s] = 4'($urandom_range(1, 8));
      cur_last[s] = ($urandom_range(0, 4) == 0);
   endtask

   task automatic model_reset();
      m_mode  = M_IDLE;
      m_gnt   = 0;
      m_ptr   = NUM_SRC - 1;
      m_words = 0;
      m_idle  = 0;
      m_ack   = 1'b0;
      m_txd   = '0;
      m_cnt   = '0;
   endtask

   task automatic model_step();
      ctrl_t e;
      logic [NUM_SRC-1:0] rdy;
      logic acc;
      logic was_last;
      int s;
      rdy = '0;
      if (m_mode == M_XFER && est && !creq && !afull) rdy[m_gnt] = 1'b1;
      e.ready = rdy;
      e.busy  = (m_mode == M_XFER);
      e.gnt   = 3'(m_gnt);
      e.ack   = m_ack;
      e.txd   = m_txd;
      e.cnt   = m_cnt;
      ctrl_q.push_back(e);
      if (!rstn) begin
         model_reset();
         return;
      end
      acc = rdy[m_gnt] && src_valid[m_gnt];
      was_last = 1'b0;
      if (acc) begin
         if (cur_b[m_gnt] != 4'd0) begin
            dq.push_back('{cyc + 1, cur_d[m_gnt], (cur_b[m_gnt] > 4'd8) ? 4'd8 : cur_b[m_gnt]});
            m_cnt++;
         end
         m_txd    = cur_d[m_gnt];
         was_last = cur_last[m_gnt];
         new_word(m_gnt);
      end
      m_ack = creq;
      if (creq) m_mode = M_CLOSE;
      else if (!est) m_mode = M_IDLE;
      else if (m_mode == M_IDLE) m_mode = M_ARB;
      else if (m_mode == M_CLOSE) m_mode = M_IDLE;
      else if (m_mode == M_ARB) begin
         for (int k = 1; k <= NUM_SRC; k++) begin
            s = (m_ptr + k) % NUM_SRC;
            if (src_valid[s]) begin
               m_gnt   = s;
               m_ptr   = s;
               m_words = 0;
               m_idle  = 0;
               m_mode  = M_XFER;
               break;
            end
         end
      end else begin
         if (acc) begin
            m_words++;
            m_idle = 0;
            if (was_last || m_words == MAX_BURST) m_mode = M_ARB;
         end else if (!src_valid[m_gnt]) begin
            m_idle++;
            if (m_idle == IDLE_TIMEOUT) m_mode = M_ARB;
         end
      end
   endtask

   initial begin
      int est_off;
      int creq_on;
      int afull_run;
      bit tail;
      rstn = 1'b0; est = 1'b0; creq = 1'b0; afull = 1'b0;
      src_valid = '0; src_last = '0; src_d = '0; src_b = '0;
      est_off = 0; creq_on = 0; afull_run = 0;
      for (int s = 0; s < NUM_SRC; s++) begin
         seq[s] = 0;
         mute[s] = 0;
         new_word(s);
      end
      model_reset();
      repeat (2) @(posedge clk);
      for (int c = 0; c < NCYC; c++) begin
         #1;
         tail = (c >= NCYC - 6);
         rstn = !(c >= 3000 && c < 3002);
         if (est_off > 0) est_off--;
         else if (!tail && $urandom_range(0, 399) == 0) est_off = $urandom_range(1, 5);
         est = (c >= 2) && (est_off == 0);
         if (creq_on > 0) creq_on--;
         else if (!tail && $urandom_range(0, 399) == 0) creq_on = $urandom_range(1, 8);
         creq = (creq_on > 0);
         if (afull_run > 0) afull_run--;
         else if (!tail && $urandom_range(0, 19) == 0) afull_run = $urandom_range(1, 6);
         afull = (afull_run > 0);
         for (int s = 0; s < NUM_SRC; s++) begin
            if (mute[s] > 0) mute[s]--;
            else if ($urandom_range(0, 199) == 0) mute[s] = $urandom_range(10, 30);
            src_valid[s]       = !tail && (mute[s] == 0) && ($urandom_range(0, 99) < 80);
            src_last[s]        = cur_last[s];
            src_d[64*s +: 64]  = cur_d[s];
            src_b[4*s +: 4]    = cur_b[s];
         end
         model_step();
         @(posedge clk);
      end
      repeat (2) @(negedge clk);
      check("scoreboard_drained", 64'(dq.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   always @(negedge clk) begin
      if (ctrl_q.size() > 0) begin
         mon_e = ctrl_q.pop_front();
         check("src_ready", 64'(src_ready), 64'(mon_e.ready));
         check("busy", 64'(busy), 64'(mon_e.busy));
         if (mon_e.busy) check("gnt_id", 64'(gnt_id), 64'(mon_e.gnt));
         check("close_ack", 64'(ack), 64'(mon_e.ack));
         check("tx_d_hold", tx_d, mon_e.txd);
         check("tx_word_cnt", 64'(tx_cnt), 64'(mon_e.cnt));
         if (dq.size() > 0 && dq[0].cyc == cyc) begin
            mon_w = dq.pop_front();
            check("tx_b", 64'(tx_b), 64'(mon_w.b));
            check("tx_d", tx_d, mon_w.d);
         end else begin
            check("tx_b_idle", 64'(tx_b), 64'd0);
         end
      end
   end

endmodule
